// File: rtl/sm83_irq_ctl_if.sv
// +--------------------------------------------------------------------+
// | sm83_irq_ctl_if : core bus / interrupt lines of sm83_irq_ctl       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface sm83_irq_ctl_if #(
    parameter int NUM_IRQS  = 8,
    parameter int IMPL_IRQS = 5
);
    logic [15:0]          adr;
    logic [7:0]           din;
    logic                 wr;
    logic                 rd;
    logic [7:0]           dout;
    logic                 dout_oe;
    logic [IMPL_IRQS-1:0] irq_req;
    logic [NUM_IRQS-1:0]  irq;
    logic [NUM_IRQS-1:0]  iack;

    modport master (
        output adr, din, wr, rd, irq_req, iack,
        input  dout, dout_oe, irq
    );

    modport slave (
        input  adr, din, wr, rd, irq_req, iack,
        output dout, dout_oe, irq
    );
endinterface

`default_nettype wire

// File: rtl/sm83_irq_ctl.sv
// +--------------------------------------------------------------------+
// | sm83_irq_ctl : IF/IE interrupt controller for the sm83 core        |
// | Optional macro SM83_IRQ_EDGE_EN: rising-edge request detection     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sm83_irq_ctl #(
    parameter int          NUM_IRQS    = 8,
    parameter int          IMPL_IRQS   = 5,
    parameter int          SYNC_STAGES = 0,
    parameter logic [15:0] IF_ADR      = 16'hFF0F,
    parameter logic [15:0] IE_ADR      = 16'hFFFF
) (
    input  logic           clk,
    input  logic           reset,
    sm83_irq_ctl_if.slave  bus
);

    logic [IMPL_IRQS-1:0] req_sync;
    logic [IMPL_IRQS-1:0] req_evt;
    logic [IMPL_IRQS-1:0] if_q;
    logic [IMPL_IRQS-1:0] if_next;
    logic [NUM_IRQS-1:0]  ie_q;
    logic [NUM_IRQS-1:0]  if_rd;
    logic [NUM_IRQS-1:0]  irq_vec;
    logic [7:0]           dout_mux;
    logic                 oe;
    logic                 if_hit;
    logic                 ie_hit;
    logic                 unused_iack;

    assign if_hit      = (bus.adr == IF_ADR);
    assign ie_hit      = (bus.adr == IE_ADR);
    assign unused_iack = ^bus.iack;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [IMPL_IRQS-1:0] stage [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= bus.irq_req;
                    for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
                end
            end
            assign req_sync = stage[SYNC_STAGES-1];
        end else begin : g_nosync
            assign req_sync = bus.irq_req;
        end
    endgenerate

`ifdef SM83_IRQ_EDGE_EN
    // prev clears on reset so a line held across reset fires once afterwards
    logic [IMPL_IRQS-1:0] req_prev;
    always_ff @(posedge clk) begin
        if (reset) req_prev <= '0;
        else       req_prev <= req_sync;
    end
    assign req_evt = req_sync & ~req_prev;
`else
    assign req_evt = req_sync;
`endif

    // Lowest priority applied first: CPU write, then ack clear, then request set
    always_comb begin
        if_next = if_q;
        if (bus.wr && if_hit) if_next = bus.din[IMPL_IRQS-1:0];
        if_next = (if_next & ~bus.iack[IMPL_IRQS-1:0]) | req_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_next;
            if (bus.wr && ie_hit) ie_q <= bus.din[NUM_IRQS-1:0];
        end
    end

    always_comb begin
        if_rd                = '1;
        if_rd[IMPL_IRQS-1:0] = if_q;
        irq_vec                = '0;
        irq_vec[IMPL_IRQS-1:0] = if_q & ie_q[IMPL_IRQS-1:0];
    end

    always_comb begin
        oe       = 1'b0;
        dout_mux = '0;
        if (bus.rd && if_hit) begin
            oe       = 1'b1;
            dout_mux = 8'(if_rd);
        end else if (bus.rd && ie_hit) begin
            oe       = 1'b1;
            dout_mux = 8'(ie_q);
        end
    end

    assign bus.irq     = irq_vec;
    assign bus.dout    = dout_mux;
    assign bus.dout_oe = oe;

endmodule

`default_nettype wire

// File: tb/tb_sm83_irq_ctl.sv
// +--------------------------------------------------------------------+
// | tb_sm83_irq_ctl : directed self-checking bench for sm83_irq_ctl    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sm83_irq_ctl;

`ifdef SM83_IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam logic [15:0] IF_A = 16'hFF0F;
    localparam logic [15:0] IE_A = 16'hFFFF;

    logic clk;
    logic reset;
    logic reset2;
    int   n_chk;
    int   n_fail;

    sm83_irq_ctl_if #(.NUM_IRQS(8), .IMPL_IRQS(5)) bus  ();
    sm83_irq_ctl_if #(.NUM_IRQS(8), .IMPL_IRQS(5)) bus2 ();

    sm83_irq_ctl #(.NUM_IRQS(8), .IMPL_IRQS(5), .SYNC_STAGES(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sm83_irq_ctl #(.NUM_IRQS(8), .IMPL_IRQS(5), .SYNC_STAGES(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [15:0] a, output logic [7:0] d, output logic o);
        bus.adr = a;
        bus.rd  = 1'b1;
        #1;
        d = bus.dout;
        o = bus.dout_oe;
        bus.rd  = 1'b0;
        bus.adr = 16'h0000;
    endtask

    task automatic rd_reg2(input logic [15:0] a, output logic [7:0] d);
        bus2.adr = a;
        bus2.rd  = 1'b1;
        #1;
        d = bus2.dout;
        bus2.rd  = 1'b0;
        bus2.adr = 16'h0000;
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        bus.adr = a;
        bus.din = d;
        bus.wr  = 1'b1;
        tick();
        bus.wr  = 1'b0;
        bus.adr = 16'h0000;
    endtask

    // one cycle of request/ack, then one idle cycle so edge mode re-arms
    task automatic pulse(input logic [4:0] req, input logic [7:0] ack);
        bus.irq_req = req;
        bus.iack    = ack;
        tick();
        bus.irq_req = '0;
        bus.iack    = '0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       o;
        n_chk++;
        if (bus.dout_oe !== 1'b0 || bus.dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle_bus: oe=%b dout=%h required oe=0 dout=00", bus.dout_oe, bus.dout);
        end
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE0 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_if: got %h oe=%b required E0 oe=1", d, o);
        end
        rd_reg(IE_A, d, o);
        n_chk++;
        if (d !== 8'h00 || o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ie: got %h oe=%b required 00 oe=1", d, o);
        end
        n_chk++;
        if (bus.irq !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_irq: got %h required 00", bus.irq);
        end
        rd_reg(16'hFF10, d, o);
        n_chk++;
        if (o !== 1'b0 || d !== 8'h00) begin
            n_fail++;
            $display("FAIL other_adr_read: oe=%b dout=%h required oe=0 dout=00", o, d);
        end
    endtask

    task automatic test_request_ack();
        logic [7:0] d;
        logic       o;
        wr_reg(IE_A, 8'h1F);
        bus.irq_req = 5'h04;
        tick();
        bus.irq_req = '0;
        n_chk++;
        if (bus.irq !== 8'h04) begin
            n_fail++;
            $display("FAIL req_irq_latency: got %h required 04", bus.irq);
        end
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE4) begin
            n_fail++;
            $display("FAIL req_if: got %h required E4", d);
        end
        tick();
        pulse(5'h00, 8'h04);
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE0 || bus.irq !== 8'h00) begin
            n_fail++;
            $display("FAIL ack_clear: if=%h irq=%h required E0/00", d, bus.irq);
        end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        logic       o;
        pulse(5'h01, 8'h00);
        pulse(5'h01, 8'h01);
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE1) begin
            n_fail++;
            $display("FAIL req_over_ack: got %h required E1", d);
        end
        bus.irq_req = 5'h10;
        wr_reg(IF_A, 8'h00);
        bus.irq_req = '0;
        tick();
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hF0) begin
            n_fail++;
            $display("FAIL req_over_write: got %h required F0", d);
        end
        wr_reg(IF_A, 8'h03);
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE3) begin
            n_fail++;
            $display("FAIL cpu_write_if: got %h required E3", d);
        end
        wr_reg(IF_A, 8'h00);
    endtask

    task automatic test_ie_gate();
        logic [7:0] d;
        logic       o;
        wr_reg(IE_A, 8'h00);
        pulse(5'h02, 8'h00);
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE2 || bus.irq !== 8'h00) begin
            n_fail++;
            $display("FAIL masked_pending: if=%h irq=%h required E2/00", d, bus.irq);
        end
        wr_reg(IE_A, 8'h02);
        n_chk++;
        if (bus.irq !== 8'h02) begin
            n_fail++;
            $display("FAIL ie_enable: irq=%h required 02", bus.irq);
        end
        wr_reg(IE_A, 8'hFF);
        rd_reg(IE_A, d, o);
        n_chk++;
        if (d !== 8'hFF || bus.irq !== 8'h02) begin
            n_fail++;
            $display("FAIL ie_all_bits: ie=%h irq=%h required FF/02", d, bus.irq);
        end
        pulse(5'h00, 8'hFF);
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE0) begin
            n_fail++;
            $display("FAIL multi_ack: if=%h required E0", d);
        end
    endtask

    task automatic test_held_request();
        logic [7:0] d;
        logic       o;
        logic [7:0] exp_h;
        exp_h = EDGE ? 8'hE0 : 8'hE8;
        bus.irq_req = 5'h08;
        tick();
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE8) begin
            n_fail++;
            $display("FAIL held_first: if=%h required E8", d);
        end
        tick();
        bus.iack = 8'h08;
        tick();
        bus.iack = '0;
        for (int i = 0; i < 8; i++) begin
            rd_reg(IF_A, d, o);
            n_chk++;
            if (d !== exp_h || bus.irq !== {3'b000, exp_h[4:0]}) begin
                n_fail++;
                $display("FAIL held_after_ack[%0d]: if=%h irq=%h required if=%h", i, d, bus.irq, exp_h);
            end
            if (i == 6) bus.irq_req = '0;
            tick();
        end
        bus.irq_req = 5'h08;
        tick();
        bus.irq_req = '0;
        rd_reg(IF_A, d, o);
        n_chk++;
        if (d !== 8'hE8) begin
            n_fail++;
            $display("FAIL held_rearm: if=%h required E8", d);
        end
        pulse(5'h00, 8'h08);
    endtask

    task automatic test_sync_stages();
        logic [7:0] d;
        bus2.adr = IE_A;
        bus2.din = 8'h01;
        bus2.wr  = 1'b1;
        tick();
        bus2.wr  = 1'b0;
        bus2.irq_req = 5'h01;
        tick();
        bus2.irq_req = '0;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (bus2.irq !== 8'h00) begin
                n_fail++;
                $display("FAIL sync_early[%0d]: irq=%h required 00", i, bus2.irq);
            end
            tick();
        end
        n_chk++;
        if (bus2.irq !== 8'h01) begin
            n_fail++;
            $display("FAIL sync_latency: irq=%h required 01", bus2.irq);
        end
        bus2.iack = 8'h01;
        tick();
        bus2.iack = '0;
        bus2.irq_req = 5'h01;
        tick();
        bus2.irq_req = '0;
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0;
        tick();
        tick();
        tick();
        rd_reg2(IF_A, d);
        n_chk++;
        if (d !== 8'hE0 || bus2.irq !== 8'h00) begin
            n_fail++;
            $display("FAIL sync_reset_discard: if=%h irq=%h required E0/00", d, bus2.irq);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        reset2  = 1'b1;
        bus.adr = '0;  bus.din = '0;  bus.wr = 1'b0;  bus.rd = 1'b0;
        bus.irq_req = '0;  bus.iack = '0;
        bus2.adr = '0; bus2.din = '0; bus2.wr = 1'b0; bus2.rd = 1'b0;
        bus2.irq_req = '0; bus2.iack = '0;
        repeat (3) tick();
        reset  = 1'b0;
        reset2 = 1'b0;
        test_reset();
        test_request_ack();
        test_collision();
        test_ie_gate();
        test_held_request();
        test_sync_stages();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
